shufsq: RTL

SHUFSQ -- requirements
Module: shufsq

---
 rtl/scu_pkg.sv | 21 ++
 rtl/scu_lfsr8.sv | 28 ++
 rtl/shufsq.sv | 62 ++++++
 3 files changed

// File: rtl/scu_pkg.sv
// Shared stochastic-computing constants: LFSR width, tap mask, default seed.
// Helpers return the next LFSR state and sanitise a seed so the LFSR never sits at zero.
// Imported by every SC block that needs a pseudo-random source.
package scu_pkg;

    localparam int          LFSR_W        = 8;
    // x^8+x^6+x^5+x^4+1 -> state bits 7,5,4,3 feed back into bit 0
    localparam logic [7:0]  LFSR_TAPS     = 8'hB8;
    localparam logic [7:0]  LFSR_SEED_DEF = 8'h01;

    // All-zero is the lock-up state of an XOR Fibonacci LFSR; map it to 1.
    function automatic logic [LFSR_W-1:0] lfsr_fix_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LFSR_SEED_DEF : s;
    endfunction

    // Shift left, parity of the tapped bits enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/scu_lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR, period 255, advances every clock.
// Latency: state is registered; reset loads seed (zero seed replaced by 8'h01).
// Ports: clk, rst_n (async active-low), seed (reset value), state (current value).
module scu_lfsr8
    import scu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    assign state_d = lfsr_next(state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= lfsr_fix_seed(seed);
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/shufsq.sv
// Stochastic squarer: out = in (x) delayed copy of in taken from an LFSR-addressed shuffle buffer.
// Latency: zero (out combinational from in); one bit consumed every cycle, no backpressure.
// Ports: clk, rst_n (async active-low), in (input bitstream), out (squared bitstream).
module shufsq
    import scu_pkg::*;
#(
    parameter int         DEPTH   = 4,            // 2, 4, 8 or 16 entries
    parameter bit         BIPOLAR = 1'b0,         // 0: AND (unipolar), 1: XNOR (bipolar)
    parameter logic [7:0] SEED    = LFSR_SEED_DEF
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [LFSR_W-1:0] lfsr;
    logic [IDX_W-1:0]  idx;
    logic              rd;
    logic [DEPTH-1:0]  shuf_q;
    logic [DEPTH-1:0]  shuf_d;

    // Only the low index bits address the buffer; the rest are consumed here
    // so they do not look like dangling logic.
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr[LFSR_W-1:IDX_W];

    scu_lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (SEED),
        .state (lfsr)
    );

    assign idx = lfsr[IDX_W-1:0];

    // Read-before-write: rd sees the entry's old content, the same entry is
    // overwritten with in at the edge.
    assign rd = shuf_q[idx];

    always_comb begin
        shuf_d      = shuf_q;
        shuf_d[idx] = in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Alternating 0,1,... : value 0.5 unipolar, 0 bipolar.
            for (int k = 0; k < DEPTH; k++) begin
                shuf_q[k] <= k[0];
            end
        end else begin
            shuf_q <= shuf_d;
        end
    end

    assign out = BIPOLAR ? ~(in ^ rd) : (in & rd);

endmodule
